fft_output_serializer: RTL and testbench
========================================

FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 Parameter DATA_W, default 32, width of each real/imag component (two's complement, passed through unmodified).
REQ-002 Parameter LOG2N, default 10, log2 of FFT frame size N; a frame is N/2 = 512 input pairs.
REQ-003 i_clk  input  1  single clock, all logic rising-edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_valid_in  input  1  one result pair present this cycle; no backpressure to upstream.
REQ-006 i_data_a_real, i_data_a_imag  input  DATA_W each  bin k of the pair (k = pair count within frame).
REQ-007 i_data_b_real, i_data_b_imag  input  DATA_W each  bin k+N/2 of the pair.
REQ-008 o_valid  output  1  output sample present.
REQ-009 i_ready  input  1  downstream accepts; transfer = o_valid & i_ready.
REQ-010 o_real, o_imag  output  DATA_W each  output sample.
REQ-011 o_index  output  LOG2N  bin number of the output sample.
REQ-012 o_sof, o_eof  output  1 each  high with bin 0 / bin N-1.
REQ-013 o_overflow  output  1  sticky: at least one frame was dropped.

Function
REQ-014 Storage: two banks (ping-pong), each N words of 2*DATA_W; per-bank full flag; write-bank pointer wsel; read-bank pointer rsel.
REQ-015 Write counter wr_cnt (LOG2N-1 bits) increments on every i_valid_in and wraps 511->0; each wrap ends a frame.
REQ-016 Pair at wr_cnt=c writes a to address {0,c} and b to address {1,c} of bank wsel in the same cycle.
REQ-017 Drop rule: at wr_cnt=0 with i_valid_in, if full[wsel]=1 (registered value) the whole frame is dropped: no writes, wr_cnt still counts, o_overflow set, no bank swap at frame end.
REQ-018 On accepting (not dropping) the pair at wr_cnt=511: full[wsel] set and wsel toggled at the same clock edge.
REQ-019 Read FSM states IDLE, PREFETCH, STREAM: IDLE->PREFETCH when full[rsel]=1; PREFETCH (one cycle, synchronous RAM read of address 0)->STREAM; STREAM->IDLE on transfer with o_eof.
REQ-020 In STREAM the sample at o_index=n is the bank word at address n (n<512: a of pair n; n>=512: b of pair n-512), giving natural bin order 0..N-1.
REQ-021 o_valid, o_real, o_imag, o_index, o_sof, o_eof are registered and held stable while o_valid=1 and i_ready=0.
REQ-022 With i_ready held high, one sample per cycle, no bubbles within a frame.
REQ-023 Latency: o_valid rises exactly 2 cycles after the edge that sets full[rsel] when FSM is IDLE.
REQ-024 On the o_eof transfer: full[rsel] cleared and rsel toggled at that edge; o_valid low next cycle; if the other bank is already full, o_valid rises again exactly 2 cycles after the eof transfer.
REQ-025 Simultaneous: a bank freed at an edge is writable from the following cycle; a wr_cnt=0 pair arriving in the freeing cycle sees full=1 and is dropped.
REQ-026 Sustained input rate above one pair per two cycles per frame average causes drops; drops never corrupt a frame being read.
REQ-027 i_ready has no effect while o_valid=0.

Reset
REQ-028 On i_reset low, asynchronously: o_valid, o_sof, o_eof, o_overflow = 0; o_real, o_imag, o_index = 0; wr_cnt = 0; wsel = rsel = 0; both full flags 0; FSM IDLE. RAM contents need not be cleared.
REQ-029 Reset mid-frame discards partial input and any frame in progress; first pair after reset release is treated as bin pair 0.
REQ-030 o_overflow clears only by reset.

Verification
REQ-031 512 pairs, a=(c, -c), b=(c+512, -(c+512)), i_ready=1 -> 1024 outputs o_real=o_index=0..1023, o_imag=-o_index, sof on 0, eof on 1023, first o_valid 2 cycles after last pair.
REQ-032 Same frame, i_ready random 50% -> identical sequence; outputs stable during stalls; no sample lost/duplicated.
REQ-033 Three frames back-to-back at 1 pair/cycle, i_ready=1 -> frames 1 and 2 output, frame 3 dropped, o_overflow=1, frame 2 output starts exactly 2 cycles after frame 1 eof.
REQ-034 Frames spaced 1100 cycles, i_ready=1 -> all frames output, o_overflow stays 0.
REQ-035 Assert reset at output sample 300 -> all outputs 0 next cycle; a fresh frame afterwards outputs bins 0..1023 correctly.
REQ-036 Pair 0 of a new frame arriving in the same cycle as the eof transfer freeing its bank -> that frame dropped, o_overflow=1.

Source files
------------

// File: rtl/fft_output_serializer_if.sv
// FFT result pair input and natural-order sample output bundle.
// The master side drives pairs and ready; the slave side is the serializer.
interface fft_output_serializer_if #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 10
);
  logic              i_valid_in;
  logic [DATA_W-1:0] i_data_a_real;
  logic [DATA_W-1:0] i_data_a_imag;
  logic [DATA_W-1:0] i_data_b_real;
  logic [DATA_W-1:0] i_data_b_imag;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_real;
  logic [DATA_W-1:0] o_imag;
  logic [LOG2N-1:0]  o_index;
  logic              o_sof;
  logic              o_eof;
  logic              o_overflow;

  modport master (
    output i_valid_in, i_data_a_real, i_data_a_imag,
    output i_data_b_real, i_data_b_imag, i_ready,
    input  o_valid, o_real, o_imag, o_index,
    input  o_sof, o_eof, o_overflow
  );

  modport slave (
    input  i_valid_in, i_data_a_real, i_data_a_imag,
    input  i_data_b_real, i_data_b_imag, i_ready,
    output o_valid, o_real, o_imag, o_index,
    output o_sof, o_eof, o_overflow
  );
endinterface

// File: rtl/fft_output_serializer.sv
// Ping-pong reorder buffer: FFT pairs (k, k+N/2) in, bins 0..N-1 out.
// Frames arriving while their bank is still being drained are dropped.
module fft_output_serializer #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 10
) (
  input logic i_clk,
  input logic i_reset,
  fft_output_serializer_if.slave bus
);
  localparam int HW = LOG2N - 1;
  localparam int NH = 1 << HW;
  localparam int WW = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM
  } state_t;

  // Half a: bins 0..N/2-1, half b: bins N/2..N-1; index {bank, pair}.
  logic [WW-1:0] mem_a [0:2*NH-1];
  logic [WW-1:0] mem_b [0:2*NH-1];

  logic [HW-1:0]     wr_cnt_q;
  logic              wsel_q;
  logic              drop_q;
  logic              ovf_q;
  logic [1:0]        full_q;
  logic [1:0]        full_d;
  logic              rsel_q;
  state_t            state_q;
  logic [LOG2N-1:0]  rd_idx_q;
  logic              valid_q;
  logic              sof_q;
  logic              eof_q;
  logic [DATA_W-1:0] real_q;
  logic [DATA_W-1:0] imag_q;
  logic [LOG2N-1:0]  index_q;

  logic          first_w;
  logic          last_w;
  logic          drop_w;
  logic          wr_en;
  logic          wr_last;
  logic          rd_xfer;
  logic          rd_done;
  logic [HW-1:0] rd_addr;
  logic [WW-1:0] rd_word;

  assign first_w = (wr_cnt_q == '0);
  assign last_w  = (wr_cnt_q == '1);
  assign drop_w  = first_w ? full_q[wsel_q] : drop_q;
  assign wr_en   = bus.i_valid_in && !drop_w;
  assign wr_last = wr_en && last_w;
  assign rd_xfer = valid_q && bus.i_ready;
  assign rd_done = (state_q == STREAM) && rd_xfer && eof_q;
  assign rd_addr = rd_idx_q[HW-1:0];
  assign rd_word = rd_idx_q[LOG2N-1] ? mem_b[{rsel_q, rd_addr}]
                                     : mem_a[{rsel_q, rd_addr}];

  // Store both halves of an accepted pair in the write bank.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_a[{wsel_q, wr_cnt_q}] <= {bus.i_data_a_real, bus.i_data_a_imag};
      mem_b[{wsel_q, wr_cnt_q}] <= {bus.i_data_b_real, bus.i_data_b_imag};
    end
  end

  // Reader frees a bank on eof; writer marks a bank full on its last pair.
  always_comb begin
    full_d = full_q;
    if (rd_done) full_d[rsel_q] = 1'b0;
    if (wr_last) full_d[wsel_q] = 1'b1;
  end

  // Write side: pair counter, frame drop decision, bank swap, overflow.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_cnt_q <= '0;
      wsel_q   <= 1'b0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      full_q   <= '0;
    end else begin
      full_q <= full_d;
      if (bus.i_valid_in) begin
        wr_cnt_q <= wr_cnt_q + HW'(1);
        if (first_w) begin
          drop_q <= full_q[wsel_q];
          if (full_q[wsel_q]) ovf_q <= 1'b1;
        end
        if (wr_last) wsel_q <= ~wsel_q;
      end
    end
  end

  // Read FSM; the output registers double as the RAM read register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      rsel_q   <= 1'b0;
      rd_idx_q <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      real_q   <= '0;
      imag_q   <= '0;
      index_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (full_q[rsel_q]) begin
            state_q  <= PREFETCH;
            rd_idx_q <= '0;
          end
        end
        PREFETCH: begin
          state_q  <= STREAM;
          valid_q  <= 1'b1;
          real_q   <= rd_word[WW-1:DATA_W];
          imag_q   <= rd_word[DATA_W-1:0];
          index_q  <= rd_idx_q;
          sof_q    <= 1'b1;
          eof_q    <= (rd_idx_q == '1);
          rd_idx_q <= rd_idx_q + LOG2N'(1);
        end
        STREAM: begin
          if (rd_xfer) begin
            if (eof_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              sof_q   <= 1'b0;
              eof_q   <= 1'b0;
              rsel_q  <= ~rsel_q;
            end else begin
              real_q   <= rd_word[WW-1:DATA_W];
              imag_q   <= rd_word[DATA_W-1:0];
              index_q  <= rd_idx_q;
              sof_q    <= 1'b0;
              eof_q    <= (rd_idx_q == '1);
              rd_idx_q <= rd_idx_q + LOG2N'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_real     = real_q;
  assign bus.o_imag     = imag_q;
  assign bus.o_index    = index_q;
  assign bus.o_sof      = sof_q;
  assign bus.o_eof      = eof_q;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench for fft_output_serializer: ordering, stalls, drops,
// back-to-back latency and reset behaviour.
module tb_fft_output_serializer;
  localparam int DW = 32;
  localparam int LN = 10;
  localparam int NB = 1024;

  logic clk;
  logic rst_n;
  int   cyc_cnt;
  int   tests;
  int   fails;

  fft_output_serializer_if #(.DATA_W(DW), .LOG2N(LN)) bus ();

  fft_output_serializer #(.DATA_W(DW), .LOG2N(LN)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [76:0] obs_f();
    return {bus.o_valid, bus.o_real, bus.o_imag, bus.o_index,
            bus.o_sof, bus.o_eof};
  endfunction

  function automatic logic [76:0] exp_f(input int n, input int off);
    logic [DW-1:0] r;
    logic [DW-1:0] im;
    logic [LN-1:0] ix;
    r  = DW'(n + off);
    im = DW'(-(n + off));
    ix = LN'(n);
    return {1'b1, r, im, ix, n == 0, n == NB - 1};
  endfunction

  task automatic idle_inputs();
    bus.i_valid_in    = 1'b0;
    bus.i_data_a_real = '0;
    bus.i_data_a_imag = '0;
    bus.i_data_b_real = '0;
    bus.i_data_b_imag = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input int off, output int first_c,
                            output int last_c);
    first_c = 0;
    for (int c = 0; c < NB / 2; c++) begin
      @(negedge clk);
      if (c == 0) first_c = cyc_cnt;
      bus.i_valid_in    = 1'b1;
      bus.i_data_a_real = DW'(c + off);
      bus.i_data_a_imag = DW'(-(c + off));
      bus.i_data_b_real = DW'(c + NB / 2 + off);
      bus.i_data_b_imag = DW'(-(c + NB / 2 + off));
    end
    last_c = cyc_cnt;
  endtask

  task automatic rx_frame(input int off, input bit rnd, input int nlim,
                          output int first_c, output int eof_c);
    int n;
    int guard;
    bit held;
    logic [76:0] snap;
    n = 0;
    guard = 0;
    held = 0;
    snap = '0;
    first_c = -1;
    eof_c = -1;
    while (n < nlim && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (held) chk("stall_hold", obs_f(), snap);
      held = 0;
      bus.i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.o_valid) begin
        if (first_c < 0) first_c = cyc_cnt;
        if (bus.i_ready) begin
          chk($sformatf("sample%0d", n), obs_f(), exp_f(n, off));
          if (n == NB - 1) eof_c = cyc_cnt;
          n++;
        end else begin
          snap = obs_f();
          held = 1;
        end
      end
    end
    if (n < nlim) chk("rx_timeout", 128'(n), 128'(nlim));
  endtask

  task automatic quiet(input string tag, input int ncyc);
    int seen;
    seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (bus.o_valid) seen++;
    end
    chk(tag, 128'(seen), 128'(0));
  endtask

  initial begin
    int f0, l0, f1, l1, f2, l2;
    int r0, e0, r1, e1, r2, e2;
    tests = 0;
    fails = 0;
    cyc_cnt = 0;
    rst_n = 1'b0;
    bus.i_ready = 1'b0;
    idle_inputs();

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", 128'(bus.o_valid), 128'(0));
    chk("rst_sof", 128'(bus.o_sof), 128'(0));
    chk("rst_eof", 128'(bus.o_eof), 128'(0));
    chk("rst_ovf", 128'(bus.o_overflow), 128'(0));
    chk("rst_real", 128'(bus.o_real), 128'(0));
    chk("rst_imag", 128'(bus.o_imag), 128'(0));
    chk("rst_index", 128'(bus.o_index), 128'(0));

    // One frame, ready high: natural order, latency 2 after last pair
    send_frame(0, f0, l0);
    @(negedge clk);
    idle_inputs();
    chk("lat_lo", 128'(bus.o_valid), 128'(0));
    bus.i_ready = 1'b1;
    rx_frame(0, 1'b0, NB, r0, e0);
    chk("lat_first", 128'(r0), 128'(l0 + 3));
    @(negedge clk);
    chk("eof_drop_valid", 128'(bus.o_valid), 128'(0));
    quiet("single_no_extra", 20);

    // Same frame, random ready: same sequence, held during stalls
    bus.i_ready = 1'b0;
    send_frame(100, f0, l0);
    @(negedge clk);
    idle_inputs();
    rx_frame(100, 1'b1, NB, r0, e0);
    chk("rnd_lat", 128'(r0), 128'(l0 + 3));
    @(negedge clk);
    bus.i_ready = 1'b1;
    quiet("rnd_no_extra", 20);
    chk("rnd_ovf", 128'(bus.o_overflow), 128'(0));

    // Three frames back-to-back: third dropped, second right after first
    fork
      begin
        send_frame(0, f0, l0);
        send_frame(4096, f1, l1);
        send_frame(8192, f2, l2);
        @(negedge clk);
        idle_inputs();
      end
      begin
        rx_frame(0, 1'b0, NB, r0, e0);
        rx_frame(4096, 1'b0, NB, r1, e1);
      end
    join
    chk("b2b_first", 128'(r0), 128'(l0 + 3));
    chk("b2b_gap", 128'(r1), 128'(e0 + 3));
    quiet("b2b_frame3_dropped", 1200);
    chk("b2b_ovf", 128'(bus.o_overflow), 128'(1));

    // Frames spaced 1100 cycles: nothing dropped
    do_reset();
    bus.i_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          send_frame(k * 2048, f0, l0);
          @(negedge clk);
          idle_inputs();
          repeat (1100 - NB / 2 - 1) @(negedge clk);
        end
      end
      begin
        rx_frame(0, 1'b0, NB, r0, e0);
        rx_frame(2048, 1'b0, NB, r1, e1);
        rx_frame(4096, 1'b0, NB, r2, e2);
      end
    join
    chk("spaced_ovf", 128'(bus.o_overflow), 128'(0));

    // Reset in the middle of output, then a clean frame
    send_frame(0, f0, l0);
    @(negedge clk);
    idle_inputs();
    rx_frame(0, 1'b0, 300, r0, e0);
    @(negedge clk);
    chk("pre_rst_idx", 128'(bus.o_index), 128'(300));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", 128'(obs_f()), 128'(0));
    @(negedge clk);
    chk("mid_rst_outs", 128'(obs_f()), 128'(0));
    chk("mid_rst_ovf", 128'(bus.o_overflow), 128'(0));
    rst_n = 1'b1;
    send_frame(77, f0, l0);
    @(negedge clk);
    idle_inputs();
    rx_frame(77, 1'b0, NB, r0, e0);
    chk("post_rst_lat", 128'(r0), 128'(l0 + 3));

    // Pair 0 lands in the cycle whose edge frees its bank: dropped
    do_reset();
    bus.i_ready = 1'b1;
    fork
      begin
        send_frame(0, f0, l0);
        send_frame(4096, f1, l1);
        @(negedge clk);
        idle_inputs();
        while (cyc_cnt < f0 + 1536) @(negedge clk);
        chk("coll_ovf_before", 128'(bus.o_overflow), 128'(0));
        send_frame(8192, f2, l2);
        @(negedge clk);
        idle_inputs();
        chk("coll_align", 128'(f2), 128'(f0 + 1537));
      end
      begin
        rx_frame(0, 1'b0, NB, r0, e0);
        rx_frame(4096, 1'b0, NB, r1, e1);
      end
    join
    chk("coll_eof_cyc", 128'(e0), 128'(f0 + 1537));
    chk("coll_gap", 128'(r1), 128'(e0 + 3));
    quiet("coll_frame_dropped", 1200);
    chk("coll_ovf", 128'(bus.o_overflow), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
